// File: rtl/fp_div_cfg.sv
// Parametrised IEEE-754 divider, radix-2 restoring, one quotient bit per cycle.
// Four rounding modes, {NV,DZ,OF,UF,NX} flags, start/done handshake.
module fp_div_cfg #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int DATA_W = 1 + EXP_W + MAN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [1:0]        rnd_mode,
    output logic [DATA_W-1:0] res,
    output logic [4:0]        flags
);

    localparam int EW   = EXP_W + 2;
    localparam int MW   = MAN_W + 1;
    localparam int QW   = MAN_W + 4;
    localparam int CW   = $clog2(QW);
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [EW-1:0] EMIN    = EW'(1 - BIAS);
    localparam logic signed [EW-1:0] EMIN_M1 = EW'(-BIAS);
    localparam logic signed [EW-1:0] EMAX    = EW'(BIAS);

    localparam logic [DATA_W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [DATA_W-2:0] INF  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [DATA_W-2:0] MAXF =
        {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

    typedef enum logic [3:0] {
        S_IDLE, S_UNPACK, S_SPECIAL, S_NORM_A, S_NORM_B,
        S_DIVIDE, S_NORM_Q, S_DENORM, S_ROUND, S_PACK
    } state_t;

    typedef struct packed {
        logic nan;
        logic snan;
        logic inf;
        logic zero;
    } cls_t;

    typedef struct packed {
        logic signed [EW-1:0] e;
        logic [MW-1:0]        m;
        cls_t                 c;
    } unp_t;

    function automatic unp_t unpack(input logic [DATA_W-1:0] x);
        unp_t u;
        logic [EXP_W-1:0] f;
        logic [MAN_W-1:0] fr;
        f = x[DATA_W-2:MAN_W];
        fr = x[MAN_W-1:0];
        u.c.zero = (f == '0) && (fr == '0);
        u.c.inf  = (&f) && (fr == '0);
        u.c.nan  = (&f) && (fr != '0);
        u.c.snan = u.c.nan && !fr[MAN_W-1];
        u.m = {(f != '0), fr};
        u.e = (f == '0) ? EMIN : $signed({2'b00, f}) - EMAX;
        return u;
    endfunction

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    opa_q, opa_d, opb_q, opb_d;
    logic [1:0]           rm_q, rm_d;
    logic                 sgn_q, sgn_d;
    logic signed [EW-1:0] ea_q, ea_d, eb_q, eb_d, ex_q, ex_d;
    logic [MW-1:0]        ma_q, ma_d, mb_q, mb_d;
    cls_t                 ca_q, ca_d, cb_q, cb_d;
    logic [MW:0]          rem_q, rem_d;
    logic [QW-1:0]        quo_q, quo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [MAN_W+2:0]     man_q, man_d;
    logic                 stk_q, stk_d;
    logic                 tiny_q, tiny_d;
    logic [MW-1:0]        sig_q, sig_d;
    logic                 nx_q, nx_d;
    logic [DATA_W-1:0]    res_q, res_d;
    logic [4:0]           flags_q, flags_d;

    unp_t        ua, ub;
    logic        ge;
    logic [MW:0] rsub;
    logic        inexact, inc, maxfin;
    logic [MW:0] sum;

    assign ua = unpack(opa_q);
    assign ub = unpack(opb_q);

    assign ge   = rem_q >= {1'b0, mb_q};
    assign rsub = ge ? rem_q - {1'b0, mb_q} : rem_q;

    // man_q = {hidden, fraction, guard, round}; sticky kept apart
    assign inexact = man_q[1] | man_q[0] | stk_q;
    assign sum     = {1'b0, man_q[MAN_W+2:2]} + {{MW{1'b0}}, inc};
    assign maxfin  = (rm_q == 2'd1) || (rm_q == 2'd2 && !sgn_q) ||
                     (rm_q == 2'd3 && sgn_q);

    always_comb begin
        inc = 1'b0;
        unique case (rm_q)
            2'd0:    inc = man_q[1] & (man_q[0] | stk_q | man_q[2]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = sgn_q & inexact;
            2'd3:    inc = ~sgn_q & inexact;
            default: inc = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rm_d    = rm_q;
        sgn_d   = sgn_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        ex_d    = ex_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        man_d   = man_q;
        stk_d   = stk_q;
        tiny_d  = tiny_q;
        sig_d   = sig_q;
        nx_d    = nx_q;
        res_d   = res_q;
        flags_d = flags_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d   = op_a;
                    opb_d   = op_b;
                    rm_d    = rnd_mode;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sgn_d   = opa_q[DATA_W-1] ^ opb_q[DATA_W-1];
                ea_d    = ua.e;
                ma_d    = ua.m;
                ca_d    = ua.c;
                eb_d    = ub.e;
                mb_d    = ub.m;
                cb_d    = ub.c;
                state_d = S_SPECIAL;
            end
            S_SPECIAL: begin
                state_d = S_IDLE;
                if (ca_q.nan || cb_q.nan) begin
                    res_d   = QNAN;
                    flags_d = {ca_q.snan | cb_q.snan, 4'b0000};
                end else if ((ca_q.zero && cb_q.zero) ||
                             (ca_q.inf && cb_q.inf)) begin
                    res_d   = QNAN;
                    flags_d = 5'b10000;
                end else if (ca_q.inf) begin
                    res_d   = {sgn_q, INF};
                    flags_d = 5'b00000;
                end else if (cb_q.zero) begin
                    res_d   = {sgn_q, INF};
                    flags_d = 5'b01000;
                end else if (cb_q.inf || ca_q.zero) begin
                    res_d   = {sgn_q, {(DATA_W-1){1'b0}}};
                    flags_d = 5'b00000;
                end else begin
                    state_d = S_NORM_A;
                end
            end
            S_NORM_A: begin
                if (ma_q[MAN_W]) begin
                    state_d = S_NORM_B;
                end else begin
                    ma_d = ma_q << 1;
                    ea_d = ea_q - 1'b1;
                end
            end
            S_NORM_B: begin
                if (mb_q[MAN_W]) begin
                    ex_d    = ea_q - eb_q;
                    rem_d   = {1'b0, ma_q};
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = S_DIVIDE;
                end else begin
                    mb_d = mb_q << 1;
                    eb_d = eb_q - 1'b1;
                end
            end
            S_DIVIDE: begin
                rem_d = rsub << 1;
                quo_d = {quo_q[QW-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(QW - 1)) state_d = S_NORM_Q;
            end
            S_NORM_Q: begin
                if (quo_q[QW-1]) begin
                    man_d   = quo_q[QW-1:1];
                    stk_d   = quo_q[0] | (rem_q != '0);
                    tiny_d  = ex_q < EMIN;
                    state_d = S_DENORM;
                end else begin
                    quo_d = quo_q << 1;
                    ex_d  = ex_q - 1'b1;
                end
            end
            S_DENORM: begin
                if (ex_q < EMIN) begin
                    man_d = man_q >> 1;
                    stk_d = stk_q | man_q[0];
                    ex_d  = ex_q + 1'b1;
                    if (ex_q == EMIN_M1) state_d = S_ROUND;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                nx_d = inexact;
                if (sum[MW]) begin
                    sig_d = sum[MW:1];
                    ex_d  = ex_q + 1'b1;
                end else begin
                    sig_d = sum[MW-1:0];
                end
                state_d = S_PACK;
            end
            S_PACK: begin
                state_d = S_IDLE;
                if (ex_q > EMAX) begin
                    flags_d = 5'b00101;
                    res_d   = {sgn_q, maxfin ? MAXF : INF};
                end else begin
                    flags_d = {3'b000, tiny_q & nx_q, nx_q};
                    res_d   = {sgn_q,
                               sig_q[MAN_W] ? EXP_W'(ex_q + EMAX)
                                            : {EXP_W{1'b0}},
                               sig_q[MAN_W-1:0]};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            rm_q    <= '0;
            sgn_q   <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            ex_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            ca_q    <= '0;
            cb_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            man_q   <= '0;
            stk_q   <= 1'b0;
            tiny_q  <= 1'b0;
            sig_q   <= '0;
            nx_q    <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rm_q    <= rm_d;
            sgn_q   <= sgn_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            ex_q    <= ex_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            man_q   <= man_d;
            stk_q   <= stk_d;
            tiny_q  <= tiny_d;
            sig_q   <= sig_d;
            nx_q    <= nx_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign done  = (state_q == S_IDLE);
    assign res   = res_q;
    assign flags = flags_q;

endmodule
